cmd_master: RTL and testbench

CMD_MASTER -- requirements
Module: cmd_master

---
 rtl/cmd_master_pkg.sv | 36 +++
 rtl/cmd_frame_mux.sv | 70 +++++++
 rtl/cmd_master.sv | 217 +++++++++++++++++++++
 tb/tb_cmd_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_master_pkg.sv
// cmd_master_pkg: shared definitions for the command master.
//   - frame opcode bytes for each command type
//   - the Cmd_type encoding (cmd_type_e)
//   - the controller FSM state encoding (state_e)
//   - resp_bytes(): number of response bytes a command expects
package cmd_master_pkg;

  localparam logic [7:0] OP_WRITE   = 8'hAA;
  localparam logic [7:0] OP_READ    = 8'hBB;
  localparam logic [7:0] OP_ALU_OP  = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_WRITE   = 2'd0,
    CMD_READ    = 2'd1,
    CMD_ALU_OP  = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // WRITE expects nothing, READ one byte, both ALU commands two bytes.
  function automatic logic [1:0] resp_bytes(input cmd_type_e t);
    case (t)
      CMD_WRITE: resp_bytes = 2'd0;
      CMD_READ:  resp_bytes = 2'd1;
      default:   resp_bytes = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/cmd_frame_mux.sv
// cmd_frame_mux: selects the outgoing frame byte for a registered command.
// Ports:
//   cmd_type_i         command type of the frame being sent
//   addr_i, fun_i      4-bit fields, zero-extended into a byte
//   data_i, a_i, b_i   operand bytes
//   idx_i              byte position within the frame
//   byte_o             byte to place on the transmit stream
//   last_o             high when idx_i is the final byte of the frame
module cmd_frame_mux
  import cmd_master_pkg::*;
#(
  parameter int width = 8
) (
  input  cmd_type_e          cmd_type_i,
  input  logic [3:0]         addr_i,
  input  logic [width-1:0]   data_i,
  input  logic [width-1:0]   a_i,
  input  logic [width-1:0]   b_i,
  input  logic [3:0]         fun_i,
  input  logic [1:0]         idx_i,
  output logic [width-1:0]   byte_o,
  output logic               last_o
);

  always_comb begin
    // NOTE: outputs get a default before the case so no path infers a latch.
    byte_o = '0;
    last_o = 1'b0;
    case (cmd_type_i)
      CMD_WRITE: begin
        case (idx_i)
          2'd0:    byte_o = width'(OP_WRITE);
          2'd1:    byte_o = width'(addr_i);
          default: begin
            byte_o = data_i;
            last_o = 1'b1;
          end
        endcase
      end
      CMD_READ: begin
        if (idx_i == 2'd0) begin
          byte_o = width'(OP_READ);
        end else begin
          byte_o = width'(addr_i);
          last_o = 1'b1;
        end
      end
      CMD_ALU_OP: begin
        case (idx_i)
          2'd0:    byte_o = width'(OP_ALU_OP);
          2'd1:    byte_o = a_i;
          2'd2:    byte_o = b_i;
          default: begin
            byte_o = width'(fun_i);
            last_o = 1'b1;
          end
        endcase
      end
      default: begin
        if (idx_i == 2'd0) begin
          byte_o = width'(OP_ALU_NOP);
        end else begin
          byte_o = width'(fun_i);
          last_o = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/cmd_master.sv
// cmd_master: turns a command request into a UART byte frame, then collects
// the response bytes and reports them as one Resp_data word.
// Ports:
//   CLK, Reset                  clock, asynchronous active-low reset
//   Cmd_valid/Cmd_ready         command handshake (ready only when idle)
//   Cmd_type/addr/data/A/B/fun  command fields, captured on acceptance
//   Tx_Data/Tx_valid/Tx_ready   outgoing byte stream (valid/ready)
//   Rx_Data/Rx_valid            incoming response bytes (one-cycle pulses)
//   Resp_data/Resp_valid        assembled response, one-cycle pulse
//   Resp_timeout                one-cycle pulse when a response never came
// Build option: define CMD_MASTER_TIMEOUT_EN to enable the response timeout
// counter (TIMEOUT cycles); otherwise WAIT_RESP waits indefinitely.
module cmd_master
  import cmd_master_pkg::*;
#(
  parameter int width   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Cmd_valid,
  output logic               Cmd_ready,
  input  logic [1:0]         Cmd_type,
  input  logic [3:0]         Cmd_addr,
  input  logic [width-1:0]   Cmd_data,
  input  logic [width-1:0]   Cmd_A,
  input  logic [width-1:0]   Cmd_B,
  input  logic [3:0]         Cmd_fun,
  output logic [width-1:0]   Tx_Data,
  output logic               Tx_valid,
  input  logic               Tx_ready,
  input  logic [width-1:0]   Rx_Data,
  input  logic               Rx_valid,
  output logic [2*width-1:0] Resp_data,
  output logic               Resp_valid,
  output logic               Resp_timeout
);

  if (width != 8) begin : g_width_chk
    $error("cmd_master: width must be 8 for frame compatibility");
  end
  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("cmd_master: TIMEOUT must be at least 2");
  end

  state_e             state_q, state_d;
  cmd_type_e          cmd_type_q, cmd_type_d;
  logic [3:0]         addr_q, addr_d;
  logic [width-1:0]   data_q, data_d;
  logic [width-1:0]   a_q, a_d;
  logic [width-1:0]   b_q, b_d;
  logic [3:0]         fun_q, fun_d;
  // Shared index: frame byte position in SEND, response byte count in WAIT_RESP.
  logic [1:0]         idx_q, idx_d;
  logic [width-1:0]   byte0_q, byte0_d;
  logic [2*width-1:0] resp_data_q, resp_data_d;
  // Registered so it stays low throughout reset and rises on the first edge after.
  logic               cmd_ready_q, cmd_ready_d;

  logic [width-1:0]   frame_byte;
  logic               frame_last;

`ifdef CMD_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic               resp_timeout_c;
`endif

  cmd_frame_mux #(.width(width)) u_frame_mux (
    .cmd_type_i (cmd_type_q),
    .addr_i     (addr_q),
    .data_i     (data_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .fun_i      (fun_q),
    .idx_i      (idx_q),
    .byte_o     (frame_byte),
    .last_o     (frame_last)
  );

  always_comb begin
    state_d     = state_q;
    cmd_type_d  = cmd_type_q;
    addr_d      = addr_q;
    data_d      = data_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    idx_d       = idx_q;
    byte0_d     = byte0_q;
    resp_data_d = resp_data_q;
`ifdef CMD_MASTER_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    resp_timeout_c = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (Cmd_valid && cmd_ready_q) begin
          cmd_type_d = cmd_type_e'(Cmd_type);
          addr_d     = Cmd_addr;
          data_d     = Cmd_data;
          a_d        = Cmd_A;
          b_d        = Cmd_B;
          fun_d      = Cmd_fun;
          idx_d      = '0;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (Tx_ready) begin
          if (frame_last) begin
            idx_d = '0;
            if (cmd_type_q == CMD_WRITE) begin
              resp_data_d = '0;
              state_d     = ST_DONE;
            end else begin
              state_d = ST_WAIT_RESP;
`ifdef CMD_MASTER_TIMEOUT_EN
              tmo_cnt_d = '0;
`endif
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      ST_WAIT_RESP: begin
        // A byte arriving in the terminal timeout cycle wins over the timeout.
        if (Rx_valid) begin
`ifdef CMD_MASTER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (idx_q == resp_bytes(cmd_type_q) - 2'd1) begin
            idx_d   = '0;
            state_d = ST_DONE;
            if (cmd_type_q == CMD_READ) begin
              resp_data_d = {{width{1'b0}}, Rx_Data};
            end else begin
              resp_data_d = {Rx_Data, byte0_q};
            end
          end else begin
            byte0_d = Rx_Data;
            idx_d   = idx_q + 2'd1;
          end
        end
`ifdef CMD_MASTER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          resp_timeout_c = 1'b1;
          idx_d          = '0;
          state_d        = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cmd_type_q  <= CMD_WRITE;
      addr_q      <= '0;
      data_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      idx_q       <= '0;
      byte0_q     <= '0;
      resp_data_q <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
      state_q     <= state_d;
      cmd_type_q  <= cmd_type_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      idx_q       <= idx_d;
      byte0_q     <= byte0_d;
      resp_data_q <= resp_data_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

`ifdef CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
  assign Resp_timeout = resp_timeout_c;
`else
  assign Resp_timeout = 1'b0;
`endif

  assign Cmd_ready  = cmd_ready_q;
  assign Tx_valid   = (state_q == ST_SEND);
  assign Tx_Data    = (state_q == ST_SEND) ? frame_byte : '0;
  assign Resp_valid = (state_q == ST_DONE);
  assign Resp_data  = resp_data_q;

endmodule

// File: tb/tb_cmd_master.sv
// tb_cmd_master: directed self-checking bench for cmd_master.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cmd_master;
  import cmd_master_pkg::*;

  localparam int W = 8;

  logic          CLK = 1'b0;
  logic          Reset = 1'b0;
  logic          Cmd_valid = 1'b0;
  logic          Cmd_ready;
  logic [1:0]    Cmd_type = 2'd0;
  logic [3:0]    Cmd_addr = 4'd0;
  logic [W-1:0]  Cmd_data = '0;
  logic [W-1:0]  Cmd_A = '0;
  logic [W-1:0]  Cmd_B = '0;
  logic [3:0]    Cmd_fun = 4'd0;
  logic [W-1:0]  Tx_Data;
  logic          Tx_valid;
  logic          Tx_ready = 1'b0;
  logic [W-1:0]  Rx_Data = '0;
  logic          Rx_valid = 1'b0;
  logic [2*W-1:0] Resp_data;
  logic          Resp_valid;
  logic          Resp_timeout;

  int   n_cmp = 0;
  int   n_err = 0;
  logic early;
  logic seen;
  logic [7:0] alu_bytes [4];

  always #5 CLK = ~CLK;

  cmd_master #(.width(W), .TIMEOUT(16)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Cmd_valid    (Cmd_valid),
    .Cmd_ready    (Cmd_ready),
    .Cmd_type     (Cmd_type),
    .Cmd_addr     (Cmd_addr),
    .Cmd_data     (Cmd_data),
    .Cmd_A        (Cmd_A),
    .Cmd_B        (Cmd_B),
    .Cmd_fun      (Cmd_fun),
    .Tx_Data      (Tx_Data),
    .Tx_valid     (Tx_valid),
    .Tx_ready     (Tx_ready),
    .Rx_Data      (Rx_Data),
    .Rx_valid     (Rx_valid),
    .Resp_data    (Resp_data),
    .Resp_valid   (Resp_valid),
    .Resp_timeout (Resp_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for Cmd_ready, presents one command for a single cycle,
  // then scrambles the fields so a design that fails to register them shows it.
  task automatic send_cmd(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] d,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    int waited = 0;
    while (Cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check("cmd_ready_before_issue", Cmd_ready, 1);
    Cmd_valid = 1'b1;
    Cmd_type  = t;
    Cmd_addr  = ad;
    Cmd_data  = d;
    Cmd_A     = a;
    Cmd_B     = b;
    Cmd_fun   = f;
    @(negedge CLK);
    Cmd_valid = 1'b0;
    Cmd_type  = ~t;
    Cmd_addr  = ~ad;
    Cmd_data  = ~d;
    Cmd_A     = ~a;
    Cmd_B     = ~b;
    Cmd_fun   = ~f;
  endtask

  // One transmitted byte with Tx_ready held high.
  task automatic tx_byte(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, Tx_valid, 1);
    check(tag, Tx_Data, exp);
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_cmd_ready", Cmd_ready, 0);
    check("rst_tx_valid", Tx_valid, 0);
    check("rst_tx_data", Tx_Data, 0);
    check("rst_resp_valid", Resp_valid, 0);
    check("rst_resp_timeout", Resp_timeout, 0);
    check("rst_resp_data", Resp_data, 0);
    Reset = 1'b1;
    @(negedge CLK);
    check("ready_first_edge", Cmd_ready, 1);

    // Stray Rx in IDLE is dropped
    Rx_valid = 1'b1;
    Rx_Data  = 8'h77;
    @(negedge CLK);
    Rx_valid = 1'b0;
    check("idle_rx_no_resp", Resp_valid, 0);

    // WRITE addr=3 data=5A
    Tx_ready = 1'b1;
    send_cmd(CMD_WRITE, 4'd3, 8'h5A, 8'h00, 8'h00, 4'h0);
    check("wr_ready_low", Cmd_ready, 0);
    tx_byte("wr_b0", 8'hAA);
    tx_byte("wr_b1", 8'h03);
    tx_byte("wr_b2", 8'h5A);
    check("wr_resp_valid", Resp_valid, 1);
    check("wr_resp_data", Resp_data, 16'h0000);
    check("wr_tx_idle", Tx_valid, 0);
    check("wr_no_timeout", Resp_timeout, 0);
    @(negedge CLK);
    check("wr_resp_pulse_end", Resp_valid, 0);
    check("b2b_ready", Cmd_ready, 1);

    // READ addr=2, response 0x81 (issued in the cycle right after DONE)
    send_cmd(CMD_READ, 4'd2, 8'h00, 8'h00, 8'h00, 4'h0);
    tx_byte("rd_b0", 8'hBB);
    tx_byte("rd_b1", 8'h02);
    check("rd_wait_tx_idle", Tx_valid, 0);
    repeat (3) @(negedge CLK);
    check("rd_no_early_resp", Resp_valid, 0);
    check("rd_ready_low_wait", Cmd_ready, 0);
    Rx_valid = 1'b1;
    Rx_Data  = 8'h81;
    @(negedge CLK);
    Rx_valid = 1'b0;
    Rx_Data  = 8'h00;
    check("rd_resp_valid", Resp_valid, 1);
    check("rd_resp_data", Resp_data, 16'h0081);
    @(negedge CLK);
    check("rd_resp_pulse_end", Resp_valid, 0);

    // ALU_OP A=10 B=20 fun=0 with Tx_ready toggling 0/1
    send_cmd(CMD_ALU_OP, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0);
    alu_bytes[0] = 8'hCC;
    alu_bytes[1] = 8'h10;
    alu_bytes[2] = 8'h20;
    alu_bytes[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      Tx_ready = 1'b0;
      check($sformatf("alu_b%0d_valid", i), Tx_valid, 1);
      check($sformatf("alu_b%0d", i), Tx_Data, alu_bytes[i]);
      @(negedge CLK);
      check($sformatf("alu_b%0d_held", i), Tx_Data, alu_bytes[i]);
      Tx_ready = 1'b1;
      @(negedge CLK);
    end
    check("alu_wait_tx_idle", Tx_valid, 0);
    Rx_valid = 1'b1;
    Rx_Data  = 8'h30;
    @(negedge CLK);
    Rx_valid = 1'b0;
    check("alu_mid_no_resp", Resp_valid, 0);
    @(negedge CLK);
    Rx_valid = 1'b1;
    Rx_Data  = 8'h00;
    @(negedge CLK);
    Rx_valid = 1'b0;
    check("alu_resp_valid", Resp_valid, 1);
    check("alu_resp_data", Resp_data, 16'h0030);
    @(negedge CLK);

    // ALU_NOP fun=2 with a stray Rx during SEND
    send_cmd(CMD_ALU_NOP, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
    Rx_valid = 1'b1;
    Rx_Data  = 8'hEE;
    tx_byte("nop_b0", 8'hDD);
    Rx_valid = 1'b0;
    tx_byte("nop_b1", 8'h02);
    Rx_valid = 1'b1;
    Rx_Data  = 8'h00;
    @(negedge CLK);
    Rx_Data  = 8'h02;
    @(negedge CLK);
    Rx_valid = 1'b0;
    check("nop_resp_valid", Resp_valid, 1);
    check("nop_resp_data", Resp_data, 16'h0200);
    @(negedge CLK);

    // READ with no response: timeout on the 16th WAIT_RESP cycle when enabled
    send_cmd(CMD_READ, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0);
    tx_byte("tmo_b0", 8'hBB);
    tx_byte("tmo_b1", 8'h01);
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (Resp_timeout !== 1'b0) early = 1'b1;
      @(negedge CLK);
    end
`ifdef CMD_MASTER_TIMEOUT_EN
    check("tmo_not_early", early, 0);
    check("tmo_pulse", Resp_timeout, 1);
    check("tmo_no_valid", Resp_valid, 0);
    @(negedge CLK);
    check("tmo_pulse_end", Resp_timeout, 0);
    check("tmo_ready_after", Cmd_ready, 1);
`else
    check("no_tmo_pin", early | Resp_timeout, 0);
    check("no_tmo_waiting", Cmd_ready, 0);
    repeat (20) @(negedge CLK);
    check("no_tmo_still_waiting", Cmd_ready, 0);
    Rx_valid = 1'b1;
    Rx_Data  = 8'h42;
    @(negedge CLK);
    Rx_valid = 1'b0;
    check("late_resp_valid", Resp_valid, 1);
    check("late_resp_data", Resp_data, 16'h0042);
    @(negedge CLK);
`endif

    // Reset pulse in the middle of a frame
    Tx_ready = 1'b0;
    send_cmd(CMD_WRITE, 4'h7, 8'h33, 8'h00, 8'h00, 4'h0);
    check("midrst_tx_valid_before", Tx_valid, 1);
    #2 Reset = 1'b0;
    #1;
    check("midrst_tx_valid", Tx_valid, 0);
    check("midrst_tx_data", Tx_Data, 0);
    check("midrst_cmd_ready", Cmd_ready, 0);
    @(negedge CLK);
    Reset    = 1'b1;
    Tx_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (Resp_valid !== 1'b0 || Tx_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_resume", seen, 0);
    check("midrst_ready", Cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
